// File: rtl/c4_pkg.sv
// Shared constants, cell codes, FSM states and axis deltas for the connect-four win scanner.
package c4_pkg;

  localparam int unsigned ROWS    = 6;
  localparam int unsigned COLS    = 7;
  localparam int unsigned CELLS   = ROWS * COLS;
  localparam int unsigned WIN_LEN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_REQ,
    ST_WAIT,
    ST_CMP,
    ST_TURN,
    ST_NEXT_AXIS,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } delta_t;

  // Axis 0 horizontal, 1 vertical, 2 down-right diagonal, 3 up-right diagonal; neg flips it.
  function automatic delta_t axis_delta(input logic [1:0] axis, input logic neg);
    delta_t d;
    case (axis)
      2'd0:    begin d.dr = 2'sd0;  d.dc = 2'sd1; end
      2'd1:    begin d.dr = 2'sd1;  d.dc = 2'sd0; end
      2'd2:    begin d.dr = 2'sd1;  d.dc = 2'sd1; end
      default: begin d.dr = -2'sd1; d.dc = 2'sd1; end
    endcase
    if (neg) begin
      d.dr = -d.dr;
      d.dc = -d.dc;
    end
    return d;
  endfunction

endpackage

// File: rtl/c4_cell_step.sv
// Combinational origin + step*delta with board bounds check; yields legality and linear cell index.
module c4_cell_step
  import c4_pkg::*;
(
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  input  logic [2:0] i_step,
  input  logic [1:0] i_axis,
  input  logic       i_neg,
  output logic       o_legal_c,
  output logic [5:0] o_idx_c
);

  delta_t            w_d;
  logic signed [3:0] w_step;
  logic signed [3:0] w_r;
  logic signed [3:0] w_c;

  assign w_d    = axis_delta(i_axis, i_neg);
  assign w_step = $signed({1'b0, i_step});

  // Deltas are only -1/0/+1, so add or subtract the step instead of multiplying.
  always_comb begin
    w_r = $signed({1'b0, i_row});
    w_c = $signed({1'b0, i_col});
    if (w_d.dr > 0)      w_r = w_r + w_step;
    else if (w_d.dr < 0) w_r = w_r - w_step;
    if (w_d.dc > 0)      w_c = w_c + w_step;
    else if (w_d.dc < 0) w_c = w_c - w_step;
  end

  assign o_legal_c = !w_r[3] && !w_c[3] &&
                     (w_r < $signed(4'(ROWS))) && (w_c < $signed(4'(COLS)));
  assign o_idx_c   = 6'(w_r[2:0]) * 6'(COLS) + 6'(w_c[2:0]);

endmodule

// File: rtl/c4_win_scanner.sv
// Walks the shared board read port along four axes from the last placed cell and reports win/draw.
// Optional macro WIN_LINE_EN enables win_axis/win_start_idx capture; otherwise those ports read 0.
module c4_win_scanner
  import c4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       new_game,
  input  logic       chk_start,
  input  logic [2:0] chk_row,
  input  logic [2:0] chk_col,
  input  logic [1:0] chk_player,
  output logic       brd_rd_en,
  output logic [5:0] brd_rd_addr,
  input  logic       brd_rd_gnt,
  input  logic [1:0] brd_rd_data,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic [1:0] win_player,
  output logic       draw,
  output logic [5:0] move_count,
  output logic [1:0] win_axis,
  output logic [5:0] win_start_idx
);

  localparam int unsigned STEP_MAX = WIN_LEN - 1;

  state_t     r_state, w_state_n;
  logic [2:0] r_row, w_row_n;
  logic [2:0] r_col, w_col_n;
  logic [2:0] r_step, w_step_n;
  logic [2:0] r_count, w_count_n;
  logic [1:0] r_player, w_player_n;
  logic [1:0] r_axis, w_axis_n;
  logic [1:0] r_rd_data, w_rd_data_n;
  logic [1:0] r_win_player, w_win_player_n;
  logic       r_dir, w_dir_n;
  logic       r_win, w_win_n;
  logic       r_draw, w_draw_n;
  logic [5:0] r_move_count, w_move_count_n;
  logic       w_take_win;

  logic       r_cell_ok;
  logic       r_rd_en;
  logic [5:0] r_rd_addr;
  logic       r_busy;
  logic       r_done;

  logic       w_legal;
  logic       w_req_ok;
  logic       w_chk_valid;
  logic [5:0] w_idx;

  assign w_chk_valid = (chk_row < 3'(ROWS)) && (chk_col < 3'(COLS)) &&
                       ((chk_player == P1) || (chk_player == P2));

  // Evaluated on next-state coordinates so the read request can be registered.
  c4_cell_step u_cell_step (
    .i_row     (w_row_n),
    .i_col     (w_col_n),
    .i_step    (w_step_n),
    .i_axis    (w_axis_n),
    .i_neg     (w_dir_n),
    .o_legal_c (w_legal),
    .o_idx_c   (w_idx)
  );

  assign w_req_ok = w_legal && (w_step_n <= 3'(STEP_MAX));

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_step       <= '0;
      r_count      <= '0;
      r_player     <= '0;
      r_axis       <= '0;
      r_rd_data    <= '0;
      r_win_player <= '0;
      r_dir        <= 1'b0;
      r_win        <= 1'b0;
      r_draw       <= 1'b0;
      r_move_count <= '0;
    end else begin
      r_state      <= w_state_n;
      r_row        <= w_row_n;
      r_col        <= w_col_n;
      r_step       <= w_step_n;
      r_count      <= w_count_n;
      r_player     <= w_player_n;
      r_axis       <= w_axis_n;
      r_rd_data    <= w_rd_data_n;
      r_win_player <= w_win_player_n;
      r_dir        <= w_dir_n;
      r_win        <= w_win_n;
      r_draw       <= w_draw_n;
      r_move_count <= w_move_count_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_row_n        = r_row;
    w_col_n        = r_col;
    w_step_n       = r_step;
    w_count_n      = r_count;
    w_player_n     = r_player;
    w_axis_n       = r_axis;
    w_rd_data_n    = r_rd_data;
    w_win_player_n = r_win_player;
    w_dir_n        = r_dir;
    w_win_n        = r_win;
    w_draw_n       = r_draw;
    w_move_count_n = r_move_count;
    w_take_win     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (chk_start && !r_win && !r_draw) begin
          if (w_chk_valid) begin
            w_row_n    = chk_row;
            w_col_n    = chk_col;
            w_player_n = chk_player;
            w_state_n  = ST_SETUP;
          end else begin
            w_state_n  = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        w_axis_n       = 2'd0;
        w_dir_n        = 1'b0;
        w_step_n       = 3'd1;
        w_count_n      = 3'd1;
        w_move_count_n = r_move_count + 6'd1;
        w_state_n      = ST_REQ;
      end
      ST_REQ: begin
        if (!r_cell_ok)      w_state_n = ST_TURN;
        else if (brd_rd_gnt) w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        w_rd_data_n = brd_rd_data;
        w_state_n   = ST_CMP;
      end
      ST_CMP: begin
        if (r_rd_data == r_player) begin
          w_count_n = r_count + 3'd1;
          if (r_count == 3'(WIN_LEN - 1)) begin
            w_win_n        = 1'b1;
            w_win_player_n = r_player;
            w_take_win     = 1'b1;
            w_state_n      = ST_DONE;
          end else begin
            w_step_n  = r_step + 3'd1;
            w_state_n = ST_REQ;
          end
        end else begin
          w_state_n = ST_TURN;
        end
      end
      ST_TURN: begin
        if (!r_dir) begin
          w_dir_n   = 1'b1;
          w_step_n  = 3'd1;
          w_state_n = ST_REQ;
        end else begin
          w_state_n = ST_NEXT_AXIS;
        end
      end
      ST_NEXT_AXIS: begin
        if (r_axis == 2'd3) begin
          if (r_move_count == 6'(CELLS)) w_draw_n = 1'b1;
          w_state_n = ST_DONE;
        end else begin
          w_axis_n  = r_axis + 2'd1;
          w_dir_n   = 1'b0;
          w_step_n  = 3'd1;
          w_count_n = 3'd1;
          w_state_n = ST_REQ;
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase

    // new_game wins over any request or scan in flight.
    if (new_game) begin
      w_state_n      = ST_IDLE;
      w_win_n        = 1'b0;
      w_win_player_n = '0;
      w_draw_n       = 1'b0;
      w_move_count_n = '0;
      w_take_win     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_cell_ok <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cell_ok <= w_req_ok;
      r_rd_en   <= (w_state_n == ST_REQ) && w_req_ok;
      r_rd_addr <= ((w_state_n == ST_REQ) && w_req_ok) ? w_idx : 6'd0;
      r_busy    <= (w_state_n != ST_IDLE);
      r_done    <= (w_state_n == ST_DONE);
    end
  end

  assign brd_rd_en   = r_rd_en;
  assign brd_rd_addr = r_rd_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign win         = r_win;
  assign win_player  = r_win_player;
  assign draw        = r_draw;
  assign move_count  = r_move_count;

`ifdef WIN_LINE_EN
  logic [1:0] r_win_axis;
  logic [5:0] r_win_start_idx;
  logic [5:0] r_cell_idx;
  logic [5:0] w_origin_idx;

  assign w_origin_idx = 6'(r_row) * 6'(COLS) + 6'(r_col);

  // A win found walking negative ends on the cell just read; walking positive it starts at the origin.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_cell_idx      <= '0;
      r_win_axis      <= '0;
      r_win_start_idx <= '0;
    end else begin
      r_cell_idx <= w_idx;
      if (new_game) begin
        r_win_axis      <= '0;
        r_win_start_idx <= '0;
      end else if (w_take_win) begin
        r_win_axis      <= r_axis;
        r_win_start_idx <= r_dir ? r_cell_idx : w_origin_idx;
      end
    end
  end

  assign win_axis      = r_win_axis;
  assign win_start_idx = r_win_start_idx;
`else
  assign win_axis      = 2'b00;
  assign win_start_idx = 6'd0;
`endif

endmodule

// File: tb/tb_c4_win_scanner.sv
// Directed self-checking bench for c4_win_scanner with a behavioural board memory behind the read port.
module tb_c4_win_scanner;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       new_game = 1'b0;
  logic       chk_start = 1'b0;
  logic [2:0] chk_row = '0;
  logic [2:0] chk_col = '0;
  logic [1:0] chk_player = '0;
  logic       gnt = 1'b1;
  logic [1:0] rd_data = '0;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       busy, done, win, draw;
  logic [1:0] win_player, win_axis;
  logic [5:0] move_count, win_start_idx;

  logic [1:0] board [0:41];
  logic       read_log [0:63];
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int cyc = 0;
  int snap = 0;
  int t0 = 0;
  int last_done_cyc = 0;
  int base_lat = 0;

  c4_win_scanner dut (
    .CLOCK_50      (clk),
    .Resetn        (rstn),
    .new_game      (new_game),
    .chk_start     (chk_start),
    .chk_row       (chk_row),
    .chk_col       (chk_col),
    .chk_player    (chk_player),
    .brd_rd_en     (rd_en),
    .brd_rd_addr   (rd_addr),
    .brd_rd_gnt    (gnt),
    .brd_rd_data   (rd_data),
    .busy          (busy),
    .done          (done),
    .win           (win),
    .win_player    (win_player),
    .draw          (draw),
    .move_count    (move_count),
    .win_axis      (win_axis),
    .win_start_idx (win_start_idx)
  );

  always #10 clk = ~clk;

  // Board memory: data for a granted read appears the next cycle and holds.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en && gnt) begin
      rd_data <= (rd_addr < 6'd42) ? board[rd_addr] : 2'b00;
      read_log[rd_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      last_done_cyc = cyc;
    end
  end

  task automatic clear_board();
    for (int i = 0; i < 42; i++) board[i] = 2'b00;
    for (int i = 0; i < 64; i++) read_log[i] = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    clear_board();
  endtask

  task automatic issue(input logic [2:0] r, input logic [2:0] c, input logic [1:0] p);
    @(negedge clk);
    snap = done_cnt;
    t0 = cyc;
    chk_row = r;
    chk_col = c;
    chk_player = p;
    chk_start = 1'b1;
    @(negedge clk);
    chk_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_cnt != snap) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (done_cnt != snap) got = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_board();
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
    n_checks++; if ({win, draw, win_player} !== 4'b0000) $display("FAIL reset_result got=%b exp=0000", {win, draw, win_player}); else n_pass++;
    n_checks++; if (move_count !== 6'd0) $display("FAIL reset_move_count got=%0d exp=0", move_count); else n_pass++;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got=%0b exp=0", rd_en); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_invalid();
    logic got;
    issue(3'd6, 3'd0, 2'b01);
    wait_done(20, got);
    n_checks++; if (got !== 1'b1) $display("FAIL inv_row_done got=%0b exp=1", got); else n_pass++;
    n_checks++; if (last_done_cyc - t0 != 1) $display("FAIL inv_row_latency got=%0d exp=1", last_done_cyc - t0); else n_pass++;
    issue(3'd0, 3'd7, 2'b10);
    wait_done(20, got);
    n_checks++; if (got !== 1'b1 || last_done_cyc - t0 != 1) $display("FAIL inv_col got_done=%0b lat=%0d exp=1/1", got, last_done_cyc - t0); else n_pass++;
    issue(3'd0, 3'd0, 2'b00);
    wait_done(20, got);
    n_checks++; if (got !== 1'b1 || last_done_cyc - t0 != 1) $display("FAIL inv_player got_done=%0b lat=%0d exp=1/1", got, last_done_cyc - t0); else n_pass++;
    n_checks++; if (move_count !== 6'd0 || win !== 1'b0 || busy !== 1'b0) $display("FAIL inv_state mc=%0d win=%0b busy=%0b exp=0/0/0", move_count, win, busy); else n_pass++;
  endtask

  task automatic setup_horizontal();
    start_game();
    board[35] = 2'b01; board[36] = 2'b01; board[37] = 2'b01; board[38] = 2'b01;
  endtask

  task automatic test_horizontal();
    logic got;
    setup_horizontal();
    issue(3'd5, 3'd3, 2'b01);
    wait_done(200, got);
    base_lat = last_done_cyc - t0;
    n_checks++; if (got !== 1'b1) $display("FAIL horiz_done got=%0b exp=1", got); else n_pass++;
    n_checks++; if (win !== 1'b1 || win_player !== 2'b01) $display("FAIL horiz_win got=%0b/%b exp=1/01", win, win_player); else n_pass++;
    n_checks++; if (move_count !== 6'd1) $display("FAIL horiz_move_count got=%0d exp=1", move_count); else n_pass++;
`ifdef WIN_LINE_EN
    n_checks++; if (win_axis !== 2'd0 || win_start_idx !== 6'd35) $display("FAIL horiz_line got=%0d/%0d exp=0/35", win_axis, win_start_idx); else n_pass++;
`else
    n_checks++; if (win_axis !== 2'd0 || win_start_idx !== 6'd0) $display("FAIL horiz_line_tied got=%0d/%0d exp=0/0", win_axis, win_start_idx); else n_pass++;
`endif
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL horiz_busy_after got=%0b exp=0", busy); else n_pass++;
    issue(3'd0, 3'd0, 2'b10);
    wait_done(30, got);
    n_checks++; if (got !== 1'b0) $display("FAIL horiz_ignore_after_win got=%0b exp=0", got); else n_pass++;
    start_game();
    n_checks++; if (win !== 1'b0 || win_player !== 2'b00 || move_count !== 6'd0) $display("FAIL new_game_clear win=%0b wp=%b mc=%0d exp=0/00/0", win, win_player, move_count); else n_pass++;
  endtask

  task automatic test_vertical();
    logic got;
    logic bad;
    start_game();
    board[27] = 2'b10; board[34] = 2'b10; board[41] = 2'b10; board[20] = 2'b10;
    issue(3'd2, 3'd6, 2'b10);
    wait_done(200, got);
    n_checks++; if (got !== 1'b1 || win !== 1'b1 || win_player !== 2'b10) $display("FAIL vert_win done=%0b win=%0b wp=%b exp=1/1/10", got, win, win_player); else n_pass++;
    bad = read_log[21];
    for (int i = 42; i < 64; i++) bad = bad | read_log[i];
    n_checks++; if (bad !== 1'b0) $display("FAIL vert_out_of_board_read got=%0b exp=0", bad); else n_pass++;
    n_checks++; if (read_log[27] !== 1'b1 || read_log[41] !== 1'b1) $display("FAIL vert_reads got=%0b%0b exp=11", read_log[27], read_log[41]); else n_pass++;
`ifdef WIN_LINE_EN
    n_checks++; if (win_axis !== 2'd1 || win_start_idx !== 6'd20) $display("FAIL vert_line got=%0d/%0d exp=1/20", win_axis, win_start_idx); else n_pass++;
`endif
  endtask

  task automatic test_diagonal();
    logic got;
    start_game();
    board[35] = 2'b01; board[29] = 2'b01; board[17] = 2'b01; board[23] = 2'b01;
    issue(3'd3, 3'd2, 2'b01);
    wait_done(200, got);
    n_checks++; if (got !== 1'b1 || win !== 1'b1 || win_player !== 2'b01) $display("FAIL diag_win done=%0b win=%0b wp=%b exp=1/1/01", got, win, win_player); else n_pass++;
`ifdef WIN_LINE_EN
    n_checks++; if (win_axis !== 2'd3 || win_start_idx !== 6'd35) $display("FAIL diag_line got=%0d/%0d exp=3/35", win_axis, win_start_idx); else n_pass++;
`endif
    start_game();
    board[28] = 2'b01; board[22] = 2'b01; board[16] = 2'b01;
    issue(3'd2, 3'd2, 2'b01);
    wait_done(200, got);
    n_checks++; if (got !== 1'b1 || win !== 1'b0 || win_player !== 2'b00) $display("FAIL diag_three done=%0b win=%0b wp=%b exp=1/0/00", got, win, win_player); else n_pass++;
    n_checks++; if (move_count !== 6'd1 || draw !== 1'b0) $display("FAIL diag_three_state mc=%0d draw=%0b exp=1/0", move_count, draw); else n_pass++;
  endtask

  task automatic test_arbitration();
    logic       got;
    logic       seen;
    logic       stable;
    logic [5:0] a0;
    setup_horizontal();
    gnt = 1'b0;
    issue(3'd5, 3'd3, 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rd_en) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL arb_req_seen got=%0b exp=1", seen); else n_pass++;
    a0 = rd_addr;
    n_checks++; if (a0 !== 6'd39) $display("FAIL arb_first_addr got=%0d exp=39", a0); else n_pass++;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rd_en !== 1'b1 || rd_addr !== a0) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL arb_hold_stable got=%0b exp=1", stable); else n_pass++;
    gnt = 1'b1;
    wait_done(200, got);
    n_checks++; if (got !== 1'b1 || win !== 1'b1 || win_player !== 2'b01) $display("FAIL arb_result done=%0b win=%0b wp=%b exp=1/1/01", got, win, win_player); else n_pass++;
    n_checks++; if (last_done_cyc - t0 != base_lat + 5) $display("FAIL arb_latency got=%0d exp=%0d", last_done_cyc - t0, base_lat + 5); else n_pass++;
  endtask

  task automatic abort_setup(output logic reached);
    setup_horizontal();
    gnt = 1'b1;
    issue(3'd5, 3'd3, 2'b01);
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en && gnt) begin
        reached = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic reached;
    logic got;
    abort_setup(reached);
    n_checks++; if (reached !== 1'b1 || busy !== 1'b1 || move_count !== 6'd1) $display("FAIL abort_ng_prep reached=%0b busy=%0b mc=%0d exp=1/1/1", reached, busy, move_count); else n_pass++;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    n_checks++; if (busy !== 1'b0 || move_count !== 6'd0 || win !== 1'b0) $display("FAIL abort_ng_state busy=%0b mc=%0d win=%0b exp=0/0/0", busy, move_count, win); else n_pass++;
    wait_done(60, got);
    n_checks++; if (got !== 1'b0) $display("FAIL abort_ng_no_done got=%0b exp=0", got); else n_pass++;

    abort_setup(reached);
    rstn = 1'b0;
    #1;
    n_checks++; if (reached !== 1'b1 || busy !== 1'b0 || move_count !== 6'd0 || win !== 1'b0) $display("FAIL abort_rst_state reached=%0b busy=%0b mc=%0d win=%0b exp=1/0/0/0", reached, busy, move_count, win); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    wait_done(60, got);
    n_checks++; if (got !== 1'b0) $display("FAIL abort_rst_no_done got=%0b exp=0", got); else n_pass++;
  endtask

  task automatic test_draw();
    logic got;
    int   missed;
    start_game();
    missed = 0;
    for (int i = 0; i < 42; i++) begin
      issue(3'(i / 7), 3'(i % 7), (i % 2 == 0) ? 2'b01 : 2'b10);
      wait_done(200, got);
      if (got !== 1'b1) missed++;
      if (i == 40) begin
        n_checks++; if (draw !== 1'b0 || move_count !== 6'd41) $display("FAIL draw_early draw=%0b mc=%0d exp=0/41", draw, move_count); else n_pass++;
      end
    end
    n_checks++; if (missed != 0) $display("FAIL draw_all_done missed=%0d exp=0", missed); else n_pass++;
    n_checks++; if (draw !== 1'b1 || win !== 1'b0 || move_count !== 6'd42) $display("FAIL draw_set draw=%0b win=%0b mc=%0d exp=1/0/42", draw, win, move_count); else n_pass++;
    issue(3'd0, 3'd0, 2'b01);
    wait_done(50, got);
    n_checks++; if (got !== 1'b0 || move_count !== 6'd42) $display("FAIL draw_ignore done=%0b mc=%0d exp=0/42", got, move_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_horizontal();
    test_vertical();
    test_diagonal();
    test_arbitration();
    test_abort();
    test_draw();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
